// File: rtl/interp_pkg.sv
// Shared types and arithmetic helpers for the interpolating rate converters.
package interp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    UNDER = 2'd3
  } state_e;

  // Rounded reciprocal of ratio in Q0.frac_w.
  function automatic int recip(input int ratio, input int frac_w);
    longint num;
    num = (longint'(1) <<< frac_w) + longint'(ratio / 2);
    return int'(num / longint'(ratio));
  endfunction

  // Round-half-up from Q.frac_w to integer, then clamp to a data_w signed range.
  function automatic longint sat_round(input longint acc, input int frac_w, input int data_w);
    longint r;
    longint hi;
    longint lo;
    r  = (acc + (longint'(1) <<< (frac_w - 1))) >>> frac_w;
    hi = (longint'(1) <<< (data_w - 1)) - 1;
    lo = -(longint'(1) <<< (data_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/interp_sat_round.sv
// Combinational round-half-up and saturate from the fixed-point accumulator to a sample.
module interp_sat_round
  import interp_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int FRAC_W = 20,
  parameter int ACC_W  = DATA_W + FRAC_W + 2
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y
);

  assign y = DATA_W'(sat_round(longint'(acc), FRAC_W, DATA_W));

endmodule

// File: rtl/interp_lin_param.sv
// Linear interpolating upsampler: one input sample per RATIO clocks, one output sample per clock,
// with a zero-order-hold mode and sticky underrun detection.
module interp_lin_param
  import interp_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int RATIO  = 50,
  parameter int FRAC_W = 20
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     mode_zoh,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     underrun
);

  localparam int CNT_W  = $clog2(RATIO);
  localparam int RECIP  = recip(RATIO, FRAC_W);
  localparam int ACC_W  = DATA_W + FRAC_W + 2;
  localparam int STEP_W = DATA_W + FRAC_W + 1;
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(RATIO - 1);
  localparam logic signed [STEP_W-1:0] RECIP_X  = STEP_W'(RECIP);

  // Handshake: a sample transfers on a rising clock edge where in_valid and in_ready are both
  // high; in_ready depends only on state and cnt, never on in_valid.
  state_e                     state;
  logic [CNT_W-1:0]           cnt;
  logic signed [DATA_W-1:0]   v;
  logic signed [DATA_W-1:0]   v_prev;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_step;
  logic signed [ACC_W-1:0]    v_acc;
  logic signed [DATA_W:0]     diff;
  logic signed [STEP_W-1:0]   diff_x;
  logic signed [STEP_W-1:0]   step;
  logic signed [DATA_W-1:0]   rounded;
  logic                       frame_end;
  logic                       transfer;

  always_comb begin
    frame_end = (cnt == CNT_LAST);
    diff      = {v[DATA_W-1], v} - {v_prev[DATA_W-1], v_prev};
    diff_x    = {{FRAC_W{diff[DATA_W]}}, diff};
    step      = mode_zoh ? '0 : diff_x * RECIP_X;
    acc_step  = acc + {step[STEP_W-1], step};
    // Reloading from v at every frame boundary discards accumulated reciprocal error.
    v_acc     = {{2{v[DATA_W-1]}}, v, {FRAC_W{1'b0}}};
    in_ready  = 1'b0;
    unique case (state)
      IDLE, PRIME, UNDER: in_ready = 1'b1;
      RUN:                in_ready = frame_end;
      default:            in_ready = 1'b0;
    endcase
    transfer  = in_valid & in_ready;
  end

  interp_sat_round #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_sat_round (
    .acc (acc),
    .y   (rounded)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      v         <= '0;
      v_prev    <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      v         <= '0;
      v_prev    <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      out_data  <= rounded;
      out_valid <= (state == RUN) || (state == UNDER);
      unique case (state)
        IDLE: begin
          if (transfer) begin
            v     <= in_data;
            state <= PRIME;
          end
        end
        PRIME, UNDER: begin
          if (transfer) begin
            v_prev <= v;
            v      <= in_data;
            acc    <= v_acc;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (!frame_end) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
          end else if (in_valid) begin
            v_prev <= v;
            v      <= in_data;
            acc    <= v_acc;
            cnt    <= '0;
          end else begin
            // Park on the last sample so the output holds flat until data returns.
            acc      <= v_acc;
            underrun <= 1'b1;
            state    <= UNDER;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
